top_filter: RTL and testbench



---
 rtl/top_filter.sv | 90 +++++++++
 tb/tb_top_filter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_filter.sv
// top_filter: synchronizer plus optional debounce for one async input.
// Ports: clk, rst (sync, active-high), a (raw async in), y (filtered),
//        rise/fall (1-cycle strobes aligned with the new y).
// Params: SYNC_STAGES (1..4), DEBOUNCE_CYCLES (1..65535).
// Macro TOP_DEBOUNCE_EN adds the debounce counter; otherwise y <= s.
module top_filter #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
      $fatal(1, "top_filter: SYNC_STAGES out of range 1..4");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
      $fatal(1, "top_filter: DEBOUNCE_CYCLES out of range 1..65535");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   y_next;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync[0] <= a;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
      end
   end

`ifdef TOP_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] cnt_next;

   assign cnt_inc = cnt + 1'b1;

   // Any agreement between s and y throws away the partial count,
   // so only an unbroken run of DEBOUNCE_CYCLES mismatches moves y.
   always_comb begin
      y_next   = y;
      cnt_next = '0;
      if (s != y) begin
         if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
            y_next = s;
         end else begin
            cnt_next = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end
`else
   always_comb begin
      y_next = s;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         y    <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         y    <= y_next;
         rise <= y_next & ~y;
         fall <= ~y_next & y;
      end
   end

endmodule

// File: tb/tb_top_filter.sv
// tb_top_filter: randomized and directed checks of top_filter
// against a history-based reference model of sync + debounce.
module tb_top_filter;

   localparam int S = 2;
   localparam int D = 4;
`ifdef TOP_DEBOUNCE_EN
   localparam int LAT = S - 1 + D;
`else
   localparam int LAT = S;
`endif
   localparam int NMAX = 4096;

   logic clk;
   logic rst;
   logic a;
   logic y;
   logic rise;
   logic fall;

   int tests;
   int fails;

   // Model history, indexed by edge number (edge 0 = before start).
   logic ah   [0:NMAX-1];
   logic rh   [0:NMAX-1];
   logic seen [0:NMAX-1];
   logic my   [0:NMAX-1];
   int   n;
   logic ey;
   logic er;
   logic ef;

   top_filter #(
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .y   (y),
      .rise(rise),
      .fall(fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one edge and advance the model; tests compare afterwards.
   task automatic step(input logic av, input logic rv);
      logic hit;
      logic all;
      a   = av;
      rst = rv;
      @(posedge clk);
      #1;
      n = n + 1;
      ah[n] = av;
      rh[n] = rv;
      // s after edge n is a from S-1 edges earlier, unless a reset
      // landed anywhere in that window.
      hit = 1'b0;
      for (int j = n - S + 1; j <= n; j++) begin
         if (j < 1 || rh[j]) hit = 1'b1;
      end
      seen[n] = hit ? 1'b0 : ah[n-S+1];
      if (rv) begin
         my[n] = 1'b0;
      end else begin
`ifdef TOP_DEBOUNCE_EN
         all = 1'b1;
         for (int k = n - D; k <= n - 1; k++) begin
            if (k < 1 || seen[k] == my[n-1]) all = 1'b0;
         end
         my[n] = all ? ~my[n-1] : my[n-1];
`else
         all   = 1'b0;
         my[n] = seen[n-1];
`endif
      end
      ey = my[n];
      er = !rv && my[n] && !my[n-1];
      ef = !rv && !my[n] && my[n-1];
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'($urandom_range(0, 1)), 1'b1);
         tests++;
         if ({y, rise, fall} !== 3'b000) begin
            fails++;
            $display("FAIL reset_hold y/rise/fall=%b%b%b want 000",
                     y, rise, fall);
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         tests++;
         if ({y, rise, fall} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle cyc %0d y/rise/fall=%b%b%b want 000",
                     i, y, rise, fall);
         end
      end
   endtask

   // Hold a at v and measure edges from E0 until y==v.
   task automatic test_edge(input logic v, input string nm);
      int lat;
      int pulses;
      lat    = -1;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         step(v, 1'b0);
         tests++;
         if (y !== ey || rise !== er || fall !== ef) begin
            fails++;
            $display("FAIL %s model k=%0d got %b%b%b want %b%b%b",
                     nm, k, y, rise, fall, ey, er, ef);
         end
         if (lat < 0 && y === v) lat = k - 1;
         if ((v ? rise : fall) === 1'b1) pulses++;
      end
      tests++;
      if (lat != LAT) begin
         fails++;
         $display("FAIL %s latency got %0d want %0d", nm, lat, LAT);
      end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL %s pulses got %0d want 1", nm, pulses);
      end
   endtask

   task automatic test_glitch();
      int rc;
      int fc;
      int exp_c;
      rc = 0;
      fc = 0;
`ifdef TOP_DEBOUNCE_EN
      exp_c = 0;
`else
      exp_c = 1;
`endif
      for (int k = 0; k < 15; k++) begin
         step((k < 3) ? 1'b1 : 1'b0, 1'b0);
         tests++;
         if (y !== ey || rise !== er || fall !== ef) begin
            fails++;
            $display("FAIL glitch model k=%0d got %b%b%b want %b%b%b",
                     k, y, rise, fall, ey, er, ef);
         end
         if (rise === 1'b1) rc++;
         if (fall === 1'b1) fc++;
      end
      tests++;
      if (rc != exp_c || fc != exp_c) begin
         fails++;
         $display("FAIL glitch pulses rise=%0d fall=%0d want %0d",
                  rc, fc, exp_c);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
      for (int k = 0; k < S - 1 + 3; k++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      tests++;
      if ({y, rise, fall} !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid after rst got %b%b%b want 000",
                  y, rise, fall);
      end
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0);
         tests++;
         if (y !== ey || rise !== er || fall !== ef) begin
            fails++;
            $display("FAIL reset_mid model k=%0d got %b%b%b want %b%b%b",
                     k, y, rise, fall, ey, er, ef);
         end
         if (lat < 0 && y === 1'b1) lat = k - 1;
      end
      tests++;
      if (lat != LAT) begin
         fails++;
         $display("FAIL reset_mid latency got %0d want %0d", lat, LAT);
      end
   endtask

   task automatic test_toggle();
      for (int k = 0; k < 24; k++) begin
         step(1'(k % 2), 1'b0);
         tests++;
         if (y !== ey || rise !== er || fall !== ef) begin
            fails++;
            $display("FAIL toggle model k=%0d got %b%b%b want %b%b%b",
                     k, y, rise, fall, ey, er, ef);
         end
`ifndef TOP_DEBOUNCE_EN
         if (k > S + 1) begin
            tests++;
            if ((rise ^ fall) !== 1'b1) begin
               fails++;
               $display("FAIL toggle strobe k=%0d rise=%b fall=%b want one",
                        k, rise, fall);
            end
         end
`endif
      end
   endtask

   task automatic test_random();
      logic av;
      int   hold;
      int   done;
      done = 0;
      while (done < 400) begin
         av   = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 2 * D + 2);
         for (int h = 0; h < hold; h++) begin
            step(av, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
            done++;
            tests++;
            if (y !== ey || rise !== er || fall !== ef ||
                (rise & fall) !== 1'b0) begin
               fails++;
               $display("FAIL random cyc %0d got %b%b%b want %b%b%b",
                        n, y, rise, fall, ey, er, ef);
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      n     = 0;
      ah[0] = 1'b0;
      rh[0] = 1'b1;
      seen[0] = 1'b0;
      my[0] = 1'b0;
      a     = 1'b0;
      rst   = 1'b1;
      test_reset();
      test_edge(1'b1, "rise");
      test_edge(1'b0, "fall");
      test_glitch();
      test_reset_mid();
      test_toggle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
